synapse_weight_store: RTL and testbench

Parametrised synaptic-weight memory with an AXI4-Lite slave port for host configuration and a dedicated single-cycle read port for the neuron cores. Generalises the fixed 16-bit weight store to configurable weight width and depth. Adds byte-strobe writes, independent AW/W acceptance, SLVERR on out-of-range writes, and core-over-host read arbitration. Sits between the host AXI interconnect and the neuron update pipeline.

---
 rtl/synapse_weight_store.sv | 154 +++++++++++++++
 tb/tb_synapse_weight_store.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/synapse_weight_store.sv
// synapse_weight_store: synaptic weight RAM with an AXI4-Lite host port and a single-cycle core read port.
// Core reads always win over host reads. A write commits on the edge where the later of AW and W is captured.
module synapse_weight_store #(
    parameter int NUM_SYNAPSES = 256,
    parameter int WEIGHT_WIDTH = 16,
    parameter int IDX_WIDTH    = $clog2(NUM_SYNAPSES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [31:0]             s_axi_wdata,
    input  logic [3:0]              s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [31:0]             s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [31:0]             s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    input  logic                    core_rd_en,
    input  logic [IDX_WIDTH-1:0]    core_rd_idx,
    output logic [WEIGHT_WIDTH-1:0] core_rd_data,
    output logic                    core_rd_valid
);
    localparam logic [1:0] SLVERR = 2'b10;

    logic [WEIGHT_WIDTH-1:0] r_mem [NUM_SYNAPSES];
    logic                    r_awready, r_wready, r_arready;
    logic                    r_aw_full, r_w_full, r_ar_full;
    logic                    r_aw_ok, r_ar_ok, r_lk;
    logic [IDX_WIDTH-1:0]    r_aw_idx, r_ar_idx;
    logic [WEIGHT_WIDTH-1:0] r_wdata;
    logic [3:0]              r_wstrb;
    logic                    r_bvalid, r_rvalid, r_crv;
    logic [1:0]              r_bresp, r_rresp;
    logic [31:0]             r_rdata;
    logic [WEIGHT_WIDTH-1:0] r_crd;

    logic                    w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic                    w_commit, w_wr_ok, w_lookup, w_core_ok;
    logic [IDX_WIDTH-1:0]    w_wr_idx;
    logic [WEIGHT_WIDTH-1:0] w_wr_data;
    logic [3:0]              w_wr_strb;
    logic                    w_unused;

    assign w_aw_hs   = s_axi_awvalid & r_awready;
    assign w_w_hs    = s_axi_wvalid & r_wready;
    assign w_b_hs    = r_bvalid & s_axi_bready;
    assign w_ar_hs   = s_axi_arvalid & r_arready;
    assign w_r_hs    = r_rvalid & s_axi_rready;
    assign w_commit  = (w_aw_hs | w_w_hs) & (w_aw_hs | r_aw_full) & (w_w_hs | r_w_full);
    assign w_wr_idx  = w_aw_hs ? s_axi_awaddr[IDX_WIDTH+1:2] : r_aw_idx;
    assign w_wr_ok   = w_aw_hs ? (s_axi_awaddr[31:2] < 30'(NUM_SYNAPSES)) : r_aw_ok;
    assign w_wr_data = w_w_hs ? s_axi_wdata[WEIGHT_WIDTH-1:0] : r_wdata;
    assign w_wr_strb = w_w_hs ? s_axi_wstrb : r_wstrb;
    // A host lookup only takes a cycle the core leaves idle.
    assign w_lookup  = r_ar_full & ~r_lk & ~r_rvalid & ~core_rd_en;
    assign w_core_ok = 32'(core_rd_idx) < 32'(NUM_SYNAPSES);
    assign w_unused  = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata};

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_arready = r_arready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;
    assign core_rd_valid = r_crv;
    assign core_rd_data  = r_crd;

    // Lanes above WEIGHT_WIDTH simply have no storage bits to write.
    always_ff @(posedge clk)
        if (w_commit && w_wr_ok)
            for (int i = 0; i < WEIGHT_WIDTH; i++)
                if (w_wr_strb[i/8]) r_mem[w_wr_idx][i] <= w_wr_data[i];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_aw_ok   <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
        end else begin
            if (w_aw_hs) begin
                r_awready <= 1'b0;
                r_aw_full <= 1'b1;
                r_aw_idx  <= w_wr_idx;
                r_aw_ok   <= w_wr_ok;
            end else if (w_b_hs) begin
                r_awready <= 1'b1;
                r_aw_full <= 1'b0;
            end else if (!r_aw_full) r_awready <= 1'b1;
            if (w_w_hs) begin
                r_wready <= 1'b0;
                r_w_full <= 1'b1;
                r_wdata  <= w_wr_data;
                r_wstrb  <= w_wr_strb;
            end else if (w_b_hs) begin
                r_wready <= 1'b1;
                r_w_full <= 1'b0;
            end else if (!r_w_full) r_wready <= 1'b1;
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? 2'b00 : SLVERR;
            end else if (w_b_hs) r_bvalid <= 1'b0;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_arready <= 1'b0;
            r_ar_full <= 1'b0;
            r_ar_ok   <= 1'b0;
            r_ar_idx  <= '0;
            r_lk      <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
            r_crv     <= 1'b0;
            r_crd     <= '0;
        end else begin
            if (w_ar_hs) begin
                r_arready <= 1'b0;
                r_ar_full <= 1'b1;
                r_ar_idx  <= s_axi_araddr[IDX_WIDTH+1:2];
                r_ar_ok   <= s_axi_araddr[31:2] < 30'(NUM_SYNAPSES);
            end else if (w_r_hs) begin
                r_arready <= 1'b1;
                r_ar_full <= 1'b0;
            end else if (!r_ar_full) r_arready <= 1'b1;
            r_lk <= w_lookup;
            if (w_lookup) begin
                r_rdata <= r_ar_ok ? 32'(r_mem[r_ar_idx]) : 32'd0;
                r_rresp <= r_ar_ok ? 2'b00 : SLVERR;
            end
            if (r_lk) r_rvalid <= 1'b1;
            else if (w_r_hs) r_rvalid <= 1'b0;
            r_crv <= core_rd_en;
            if (core_rd_en) r_crd <= w_core_ok ? r_mem[core_rd_idx] : '0;
        end
endmodule

// File: tb/tb_synapse_weight_store.sv
// tb_synapse_weight_store: directed vectors for synapse_weight_store (256 x 16-bit).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_synapse_weight_store;
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] s_axi_awaddr = '0, s_axi_wdata = '0, s_axi_araddr = '0;
    logic        s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b0;
    logic        s_axi_arvalid = 1'b0, s_axi_rready = 1'b0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic [31:0] s_axi_rdata;
    logic        core_rd_en = 1'b0;
    logic [7:0]  core_rd_idx = '0;
    logic [15:0] core_rd_data;
    logic        core_rd_valid;
    int          n_checks = 0, n_errors = 0;
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat, cv;

    synapse_weight_store #(.NUM_SYNAPSES(256), .WEIGHT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .core_rd_en(core_rd_en),
        .core_rd_idx(core_rd_idx), .core_rd_data(core_rd_data), .core_rd_valid(core_rd_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
        int n;
        logic aw_hs, w_hs;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
        n = 0;
        while ((s_axi_awvalid || s_axi_wvalid) && n < 20) begin
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            tick; n++;
            if (aw_hs) s_axi_awvalid = 1'b0;
            if (w_hs) s_axi_wvalid = 1'b0;
        end
        while (!s_axi_bvalid && n < 20) begin tick; n++; end
        check("wr_done", n < 20, 1'b1);
        r = s_axi_bresp;
        tick;
        s_axi_bready = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                            output int l);
        int n;
        s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 20) begin tick; n++; end
        tick;
        s_axi_arvalid = 1'b0;
        l = 0;
        while (!s_axi_rvalid && l < 20) begin tick; l++; end
        check("rd_done", l < 20 && n < 20, 1'b1);
        d = s_axi_rdata; r = s_axi_rresp;
        tick;
        s_axi_rready = 1'b0;
    endtask

    task automatic core_read(input logic [7:0] idx, output logic [31:0] d);
        core_rd_en = 1'b1; core_rd_idx = idx;
        tick;
        core_rd_en = 1'b0;
        check("core_valid", core_rd_valid, 1'b1);
        d = 32'(core_rd_data);
    endtask

    initial begin
        tick; tick;
        check("rst_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
        check("rst_valid", {s_axi_bvalid, s_axi_rvalid, core_rd_valid}, 3'b000);
        check("rst_data", {s_axi_rdata, s_axi_bresp, s_axi_rresp}, '0);
        check("rst_core_data", 32'(core_rd_data), 32'h0);
        rst = 1'b0;
        tick;
        check("ready_rise", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

        // AW in cycle 0, W in cycle 3, bvalid in cycle 4.
        s_axi_awaddr = 32'h10; s_axi_awvalid = 1'b1;
        tick;
        s_axi_awvalid = 1'b0;
        check("aw_held", {s_axi_awready, s_axi_wready, s_axi_bvalid}, 3'b010);
        tick; tick;
        s_axi_wdata = 32'h0000BEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        tick;
        s_axi_wvalid = 1'b0;
        check("b_rise", {s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready}, 5'b1_00_00);
        tick;
        check("b_hold", s_axi_bvalid, 1'b1);
        s_axi_bready = 1'b1;
        tick;
        s_axi_bready = 1'b0;
        check("b_done", {s_axi_bvalid, s_axi_awready, s_axi_wready}, 3'b011);
        axi_read(32'h10, data, resp, lat);
        check("rd_beef", data, 32'h0000BEEF);
        check("rd_beef_resp", resp, 2'b00);
        check("rd_min_lat", lat, 2);
        check("ar_rerise", s_axi_arready, 1'b1);

        // Byte-lane write into a 16-bit weight.
        axi_write(32'h14, 32'h1234, 4'hF, resp);
        axi_write(32'h14, 32'hFFFFAB00, 4'b0010, resp);
        check("strb_resp", resp, 2'b00);
        core_read(8'd5, data);
        check("strb_core", data, 32'hAB34);
        tick;
        check("core_valid_drop", core_rd_valid, 1'b0);
        axi_write(32'h14, 32'h00FF0000, 4'b0100, resp);
        axi_read(32'h14, data, resp, lat);
        check("lane2_ignored", data, 32'h0000AB34);

        // W before AW.
        s_axi_wdata = 32'h3333; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        tick;
        s_axi_wvalid = 1'b0;
        check("w_first_held", {s_axi_wready, s_axi_awready, s_axi_bvalid}, 3'b010);
        s_axi_awaddr = 32'h0C; s_axi_awvalid = 1'b1;
        tick;
        s_axi_awvalid = 1'b0;
        check("w_first_b", s_axi_bvalid, 1'b1);
        s_axi_bready = 1'b1;
        tick;
        s_axi_bready = 1'b0;
        core_read(8'd3, data);
        check("w_first_data", data, 32'h3333);

        // Out-of-range index; 0x400 aliases index 0 in its low bits.
        axi_write(32'h0, 32'h5A5A, 4'hF, resp);
        axi_write(32'h400, 32'hDEAD, 4'hF, resp);
        check("oor_bresp", resp, 2'b10);
        core_read(8'd0, data);
        check("oor_no_change", data, 32'h5A5A);
        axi_read(32'h400, data, resp, lat);
        check("oor_rdata", data, 32'h0);
        check("oor_rresp", resp, 2'b10);
        axi_write(32'h3FC, 32'h7777, 4'hF, resp);
        check("last_bresp", resp, 2'b00);
        axi_read(32'h3FC, data, resp, lat);
        check("last_rdata", data, 32'h7777);

        // Core priority: 5 core cycles stretch host read to 7 edges.
        axi_write(32'h1C, 32'h0707, 4'hF, resp);
        s_axi_araddr = 32'h1C; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        tick;
        s_axi_arvalid = 1'b0;
        core_rd_en = 1'b1; core_rd_idx = 8'd7;
        lat = 0; cv = 0;
        while (!s_axi_rvalid && lat < 20) begin
            if (lat == 5) core_rd_en = 1'b0;
            tick; lat++;
            if (core_rd_valid) cv++;
        end
        check("prio_lat", lat, 7);
        check("prio_core_cnt", cv, 5);
        check("prio_core_data", 32'(core_rd_data), 32'h0707);
        check("prio_rdata", {s_axi_rdata, s_axi_rresp}, {32'h0707, 2'b00});
        tick;
        s_axi_rready = 1'b0;
        check("prio_r_done", {s_axi_rvalid, s_axi_arready}, 2'b01);

        // Read-first on same-cycle commit.
        axi_write(32'h24, 32'h0011, 4'hF, resp);
        s_axi_awaddr = 32'h24; s_axi_wdata = 32'h0055; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        core_rd_en = 1'b1; core_rd_idx = 8'd9;
        tick;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("rf_old", 32'(core_rd_data), 32'h0011);
        check("rf_bvalid", s_axi_bvalid, 1'b1);
        tick;
        core_rd_en = 1'b0;
        check("rf_new", 32'(core_rd_data), 32'h0055);
        s_axi_bready = 1'b1;
        tick;
        s_axi_bready = 1'b0;

        // Reset with a pending write response.
        s_axi_awaddr = 32'h28; s_axi_wdata = 32'h1111; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        tick;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("pre_rst_b", s_axi_bvalid, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_async_b", s_axi_bvalid, 1'b0);
        check("rst_async_rdy", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
        tick;
        rst = 1'b0;
        check("rel_rdy_low", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
        tick;
        check("rel_rdy_high", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
        axi_write(32'h28, 32'h4242, 4'hF, resp);
        check("post_rst_bresp", resp, 2'b00);
        axi_read(32'h28, data, resp, lat);
        check("post_rst_rdata", data, 32'h4242);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
